// File: rtl/e_mdu_sched_if.sv
// e_mdu_sched_if: E-stage multiply/divide request and response bundle.
interface e_mdu_sched_if;
    logic        en;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        D_isMD;
    logic [31:0] MDOut;
    logic        busy;
    logic        stall;
    modport master (output en, MDUOp, A, B, D_isMD, input MDOut, busy, stall);
    modport slave  (input en, MDUOp, A, B, D_isMD, output MDOut, busy, stall);
endinterface

// File: rtl/e_mdu_sched.sv
// e_mdu_sched: fixed-latency mult/div scheduler owning HI/LO, serving mf/mt ops and the D-stage stall.
// MDU_DIV0_HOLD_EN: divide-by-zero keeps HI/LO instead of committing LO=all-ones, HI=A.
module e_mdu_sched #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input logic          clk,
    input logic          reset,
    e_mdu_sched_if.slave m
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic        busy;
    logic [31:0] hi, lo, pend_hi, pend_lo;
    logic [3:0]  op;
    logic        is_mul, is_div, start, div0, ovf;
    logic [63:0] prod_s, prod_u;
    logic [31:0] dvs, q_s, r_s, q_u, r_u, div0_hi, div0_lo, res_hi, res_lo;

    assign op     = m.en ? m.MDUOp : 4'd0;
    assign is_mul = op == 4'd1 || op == 4'd2;
    assign is_div = op == 4'd3 || op == 4'd4;
    assign start  = (is_mul || is_div) && state == IDLE;
    assign prod_s = $signed({{32{m.A[31]}}, m.A}) * $signed({{32{m.B[31]}}, m.B});
    assign prod_u = {32'd0, m.A} * {32'd0, m.B};
    assign div0   = m.B == 32'd0;
    assign ovf    = m.A == 32'h8000_0000 && m.B == 32'hFFFF_FFFF;
    // Dividing by 1 instead yields exactly the required 0x80000000 / -1 result and keeps B==0 X-free.
    assign dvs    = (div0 || ovf) ? 32'd1 : m.B;
    assign q_s    = 32'($signed(m.A) / $signed(dvs));
    assign r_s    = 32'($signed(m.A) % $signed(dvs));
    assign q_u    = m.A / dvs;
    assign r_u    = m.A % dvs;
`ifdef MDU_DIV0_HOLD_EN
    assign div0_hi = hi;
    assign div0_lo = lo;
`else
    assign div0_hi = m.A;
    assign div0_lo = 32'hFFFF_FFFF;
`endif
    assign res_hi = op == 4'd1 ? prod_s[63:32] : op == 4'd2 ? prod_u[63:32] :
                    div0 ? div0_hi : op == 4'd3 ? r_s : r_u;
    assign res_lo = op == 4'd1 ? prod_s[31:0] : op == 4'd2 ? prod_u[31:0] :
                    div0 ? div0_lo : op == 4'd3 ? q_s : q_u;
    assign m.MDOut = op == 4'd5 ? hi : op == 4'd6 ? lo : 32'd0;
    assign m.busy  = busy;
    assign m.stall = m.D_isMD && (busy || start);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cnt     <= 4'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
        end else if (state == IDLE) begin
            if (start) begin
                state   <= BUSY;
                busy    <= 1'b1;
                cnt     <= is_mul ? 4'(MUL_CYCLES) : 4'(DIV_CYCLES);
                pend_hi <= res_hi;
                pend_lo <= res_lo;
            end else if (op == 4'd7) begin
                hi <= m.A;
            end else if (op == 4'd8) begin
                lo <= m.A;
            end
        end else if (cnt == 4'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= 4'd0;
            hi    <= pend_hi;
            lo    <= pend_lo;
        end else begin
            cnt <= cnt - 4'd1;
        end
    end
endmodule

// File: tb/tb_e_mdu_sched.sv
// tb_e_mdu_sched: scoreboard bench for e_mdu_sched; HI/LO expectations come from a 64-bit arithmetic model.
module tb_e_mdu_sched;
    localparam int MUL_N = 5;
    localparam int DIV_N = 10;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          total = 0;
    int          bad = 0;
    logic [31:0] ref_hi = 32'd0;
    logic [31:0] ref_lo = 32'd0;
    logic [31:0] exp_q[$];

    e_mdu_sched_if m();
    e_mdu_sched #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (.clk(clk), .reset(reset), .m(m));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every mfhi/mflo the DUT serves consumes one queued expectation.
    always @(negedge clk)
        if (!reset && m.en && (m.MDUOp == 4'd5 || m.MDUOp == 4'd6)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mdout_unexpected actual=%h required=<none queued>", m.MDOut);
            end else begin
                chk("mdout", m.MDOut, exp_q.pop_front());
            end
        end

    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ma, mb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if ((op == 4'd3 || op == 4'd4) && b == 32'd0) begin
`ifndef MDU_DIV0_HOLD_EN
            ref_hi = a;
            ref_lo = 32'hFFFF_FFFF;
`endif
        end else begin
            case (op)
                4'd1: begin p = 64'(sa * sb); {ref_hi, ref_lo} = p; end
                4'd2: begin p = {32'd0, a} * {32'd0, b}; {ref_hi, ref_lo} = p; end
                4'd3: begin
                    ma = sa < 0 ? -sa : sa;
                    mb = sb < 0 ? -sb : sb;
                    q = ma / mb;
                    r = ma % mb;
                    if ((sa < 0) != (sb < 0)) q = -q;
                    if (sa < 0) r = -r;
                    ref_lo = 32'(q);
                    ref_hi = 32'(r);
                end
                4'd4: begin ref_lo = a / b; ref_hi = a % b; end
                4'd5: exp_q.push_back(ref_hi);
                4'd6: exp_q.push_back(ref_lo);
                4'd7: ref_hi = a;
                4'd8: ref_lo = a;
                default: ;
            endcase
        end
    endtask

    task automatic mdu_op(input logic e, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic dm);
        logic act;
        int n;
        act = e && op >= 4'd1 && op <= 4'd4;
        @(posedge clk); #1;
        m.en = e; m.MDUOp = op; m.A = a; m.B = b; m.D_isMD = dm;
        if (e) model(op, a, b);
        @(negedge clk);
        chk("stall_issue", 32'(m.stall), 32'(act && dm));
        @(posedge clk); #1;
        m.en = 1'b0; m.MDUOp = 4'd0;
        n = 0;
        if (act) begin
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (!m.busy) break;
                n++;
                chk("stall_busy", 32'(m.stall), 32'(dm));
            end
            chk("busy_len", 32'(n), op <= 4'd2 ? 32'(MUL_N) : 32'(DIV_N));
            chk("stall_after", 32'(m.stall), 32'd0);
        end else begin
            @(negedge clk);
            chk("busy_idle", 32'(m.busy), 32'd0);
        end
    endtask

    task automatic rdc(input logic [3:0] op, input logic [31:0] v);
        @(posedge clk); #1;
        m.en = 1'b1; m.MDUOp = op; m.D_isMD = 1'b0;
        exp_q.push_back(v);
        @(posedge clk); #1;
        m.en = 1'b0; m.MDUOp = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        int          r;
        m.en = 1'b0; m.MDUOp = 4'd0; m.A = 32'd0; m.B = 32'd0; m.D_isMD = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(m.busy), 32'd0);
        chk("reset_stall", 32'(m.stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        rdc(4'd5, 32'd0);
        rdc(4'd6, 32'd0);
        mdu_op(1'b1, 4'd1, -32'sd3, 32'd7, 1'b1);
        rdc(4'd6, 32'hFFFF_FFEB);
        rdc(4'd5, 32'hFFFF_FFFF);
        mdu_op(1'b1, 4'd4, 32'd100, 32'd7, 1'b0);
        rdc(4'd6, 32'd14);
        rdc(4'd5, 32'd2);
        mdu_op(1'b1, 4'd3, -32'sd7, 32'd2, 1'b1);
        rdc(4'd6, 32'hFFFF_FFFD);
        rdc(4'd5, 32'hFFFF_FFFF);
        mdu_op(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        rdc(4'd6, 32'h8000_0000);
        rdc(4'd5, 32'd0);
        mdu_op(1'b1, 4'd7, 32'h55, 32'd0, 1'b0);
        mdu_op(1'b1, 4'd8, 32'h66, 32'd0, 1'b0);
        mdu_op(1'b1, 4'd3, 32'h12, 32'd0, 1'b1);
`ifdef MDU_DIV0_HOLD_EN
        rdc(4'd5, 32'h55);
        rdc(4'd6, 32'h66);
`else
        rdc(4'd5, 32'h12);
        rdc(4'd6, 32'hFFFF_FFFF);
`endif
        mdu_op(1'b1, 4'd7, 32'hABCD, 32'd0, 1'b1);
        rdc(4'd5, 32'hABCD);
        mdu_op(1'b0, 4'd7, 32'h1234, 32'd0, 1'b0);
        mdu_op(1'b0, 4'd1, 32'd9, 32'd9, 1'b1);
        rdc(4'd5, 32'hABCD);
        mdu_op(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
        // Reset lands in the fourth busy cycle of a divide; the pending result must never appear.
        @(posedge clk); #1;
        m.en = 1'b1; m.MDUOp = 4'd3; m.A = 32'd100; m.B = 32'd7;
        @(posedge clk); #1;
        m.en = 1'b0; m.MDUOp = 4'd0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("busy_async_reset", 32'(m.busy), 32'd0);
        ref_hi = 32'd0;
        ref_lo = 32'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("busy_after_reset", 32'(m.busy), 32'd0);
        rdc(4'd5, 32'd0);
        rdc(4'd6, 32'd0);
        for (int i = 0; i < 80; i++) begin
            op = 4'($urandom_range(0, 10));
            a = $urandom;
            b = $urandom;
            r = int'($urandom_range(0, 7));
            if (r == 0) b = 32'd0;
            if (r == 1) b = 32'hFFFF_FFFF;
            if (r == 2) a = 32'h8000_0000;
            if (r == 3) b = 32'($urandom_range(1, 20));
            mdu_op($urandom_range(0, 7) != 0, op, a, b, 1'($urandom));
            if (r >= 6) mdu_op(1'b1, 4'($urandom_range(5, 6)), 32'd0, 32'd0, 1'b0);
        end
        mdu_op(1'b1, 4'd5, 32'd0, 32'd0, 1'b0);
        mdu_op(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
